// File: rtl/ag_prio_parity_stream_if.sv
// Stream-side bundle for ag_prio_parity_stream. The slave modport is the tile and the master modport is its driver.
interface ag_prio_parity_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
);
  localparam int IDXW = $clog2(WIDTH);

  logic             ena;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_par;
  logic             err_clr;

  logic             enc_valid;
  logic [IDXW-1:0]  enc_idx;
  logic             enc_any;
  logic             frame_done;
  logic             parity_err;
  logic             ovf;
  logic             busy;
  logic [CNTW-1:0]  err_count;

  modport master (
    output ena, in_valid, in_data, in_last, in_par, err_clr,
    input  enc_valid, enc_idx, enc_any, frame_done, parity_err, ovf, busy, err_count
  );

  modport slave (
    input  ena, in_valid, in_data, in_last, in_par, err_clr,
    output enc_valid, enc_idx, enc_any, frame_done, parity_err, ovf, busy, err_count
  );
endinterface

// File: rtl/ag_prio_parity_stream.sv
// Pipelined priority encoder and frame parity checker.
// It forces a frame to end when the frame reaches MAX_FRAME words, and it keeps a saturating count of errored frames.
module ag_prio_parity_stream #(
  parameter int WIDTH      = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int MAX_FRAME  = 16,
  parameter int CNTW       = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  ag_prio_parity_stream_if.slave bus
);
  localparam int IDXW = $clog2(WIDTH);
  localparam int CW   = $clog2(MAX_FRAME + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          r_state;
  logic            r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_enc_valid;
  logic [IDXW-1:0] r_enc_idx;
  logic            r_enc_any;
  logic            r_frame_done;
  logic            r_parity_err;
  logic            r_ovf;
  logic [CNTW-1:0] r_err_count;

  logic            w_acc_w;
  logic            w_word_par;
  logic            w_acc_total;
  logic            w_last_cnt;
  logic            w_end;
  logic            w_ovf;
  logic            w_perr;
  logic            w_err_inc;
  logic [IDXW-1:0] w_idx;

  // Later set bits overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_data[i]) w_idx = IDXW'(i);
    end
  end

  // The word counter is zero while IDLE, so a single compare covers the MAX_FRAME=1 case as well.
  assign w_acc_w     = bus.ena & bus.in_valid;
  assign w_word_par  = ^bus.in_data;
  assign w_acc_total = r_acc ^ w_word_par;
  assign w_last_cnt  = ((int'(r_cnt) + 1) == MAX_FRAME);
  assign w_end       = w_acc_w & (bus.in_last | w_last_cnt);
  assign w_ovf       = w_acc_w & ~bus.in_last & w_last_cnt;
  assign w_perr      = w_ovf | (w_acc_total ^ bus.in_par ^ ODD_PARITY);
  assign w_err_inc   = w_end & w_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_acc        <= 1'b0;
      r_cnt        <= '0;
      r_enc_valid  <= 1'b0;
      r_enc_idx    <= '0;
      r_enc_any    <= 1'b0;
      r_frame_done <= 1'b0;
      r_parity_err <= 1'b0;
      r_ovf        <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_enc_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
      if (bus.ena) begin
        if (bus.in_valid) begin
          r_enc_valid <= 1'b1;
          r_enc_idx   <= w_idx;
          r_enc_any   <= |bus.in_data;
          if (w_end) begin
            r_frame_done <= 1'b1;
            r_parity_err <= w_perr;
            r_ovf        <= w_ovf;
            r_state      <= IDLE;
            r_acc        <= 1'b0;
            r_cnt        <= '0;
          end else begin
            r_state <= ACCUM;
            r_acc   <= w_acc_total;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        // A clear that coincides with a new error keeps that error in the count.
        if (bus.err_clr) begin
          r_err_count <= w_err_inc ? CNTW'(1) : '0;
        end else if (w_err_inc && (r_err_count != {CNTW{1'b1}})) begin
          r_err_count <= r_err_count + CNTW'(1);
        end
      end
    end
  end

  assign bus.enc_valid  = r_enc_valid;
  assign bus.enc_idx    = r_enc_idx;
  assign bus.enc_any    = r_enc_any;
  assign bus.frame_done = r_frame_done;
  assign bus.parity_err = r_parity_err;
  assign bus.ovf        = r_ovf;
  assign bus.busy       = (r_state == ACCUM);
  assign bus.err_count  = r_err_count;
endmodule

// File: doc/ag_prio_parity_stream.md
Name: ag_prio_parity_stream

Overview:
- Parametrised, pipelined successor to the combinational priority-encoder/parity-checker tile.
- Per input word: registers a highest-set-bit index.
- Per multi-word frame: accumulates parity and checks it against a supplied parity bit, with frame-length overflow detection.
- Keeps a saturating error counter. Sits between the tile's input pins and its output/status pins.

Parameters:
- WIDTH, 8, data word width (>=2); IDXW = $clog2(WIDTH).
- ODD_PARITY, 0, 0 = even parity expected over frame data plus parity bit; 1 = odd.
- MAX_FRAME, 16, maximum words per frame (>=1) before forced termination.
- CNTW, 8, width of the error counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  enable; low = freeze state, ignore inputs.
- in_valid  in  1  word present this cycle (no backpressure; always accepted when ena=1).
- in_data  in  WIDTH  data word.
- in_last  in  1  qualifies the final word of a frame.
- in_par  in  1  expected parity bit, sampled only with in_valid&in_last.
- err_clr  in  1  synchronous clear of err_count.
- enc_valid  out  1  one-cycle pulse: enc_idx/enc_any are fresh.
- enc_idx  out  IDXW  index of the highest set bit of the last accepted word.
- enc_any  out  1  last accepted word was nonzero.
- frame_done  out  1  one-cycle pulse: frame ended.
- parity_err  out  1  error flag, valid while frame_done=1; holds otherwise.
- ovf  out  1  one-cycle pulse with frame_done when the frame was forcibly ended.
- busy  out  1  FSM in ACCUM.
- err_count  out  CNTW  count of errored frames, saturating.

Behaviour:
- Reset (rst_n low, async): all outputs 0, accumulator 0, word counter 0, FSM IDLE. Reset mid-frame discards the frame with no frame_done.
- Accept condition: acc_w = ena & in_valid.
- ena=0: all registers hold, except enc_valid, frame_done and ovf, which are forced 0.
- Encoder (latency 1):
  - On acc_w, the next cycle has enc_valid=1, enc_any=|in_data, enc_idx = highest set bit index.
  - in_data=0 gives enc_idx=0, enc_any=0.
  - Without acc_w, enc_valid=0 and enc_idx/enc_any hold.
- FSM state IDLE: acc=0, cnt=0.
  - acc_w & in_last: single-word frame; report; stay in IDLE.
  - acc_w & !in_last: acc=^in_data, cnt=1, go to ACCUM.
  - MAX_FRAME=1 & !in_last: forced end (see overflow).
- FSM state ACCUM (busy=1): on acc_w, acc^=^in_data, cnt++.
  - in_last: report, go to IDLE.
  - Else if cnt+1==MAX_FRAME: overflow, go to IDLE.
- Report (registered, visible the cycle after the last word): frame_done=1, parity_err = acc_total ^ in_par ^ ODD_PARITY, where acc_total includes the last word.
- Overflow: the word that makes the count reach MAX_FRAME without in_last ends the frame. Next cycle: frame_done=1, ovf=1, parity_err=1; in_par ignored.
- Back-to-back: a word accepted in the cycle frame_done is high belongs to the next frame. Frames may be contiguous with no idle cycle.
- err_count: updated on the same edge that raises frame_done with parity_err=1; saturates at 2^CNTW-1.
  - err_clr alone: err_count becomes 0 at the next edge.
  - err_clr coinciding with an increment: err_count becomes 1.
- in_last without in_valid: ignored.

Test Plan:
1. Assert rst_n low for 3 cycles mid-frame, then release -> all outputs 0, busy=0; next frame is counted from its first word, with no stale frame_done.
2. WIDTH=8 single word 0x2C, in_last=1, in_par=1 -> next cycle enc_valid=1, enc_idx=5, enc_any=1, frame_done=1, parity_err=0, err_count=0.
3. Word 0x00 (in_last=0) then 0x80 -> enc_any=0/enc_idx=0, then enc_any=1/enc_idx=7; busy=1 after the first word.
4. Frame 0x01, 0x03, 0x80(last) with in_par=1 -> frame_done one cycle after 0x80, parity_err=1, err_count=1. Repeat with in_par=0 -> parity_err=0, err_count stays 1.
5. MAX_FRAME=4: send 4 words with no in_last -> after the 4th, frame_done=1, ovf=1, parity_err=1, busy=0. A 5th word in that cycle starts a new frame (busy=1).
6. CNTW=2: 4 errored frames -> err_count=3 (saturated). Then err_clr on the same edge as an errored frame -> err_count=1. Toggle ena=0 mid-frame for 5 cycles -> no pulses, and the frame resumes correctly.
